hello_seq_ctrl: RTL and testbench
=================================

// Module: hello_seq_ctrl
// PURPOSE
//  Upstream control stage for the seven-segment "HELLO" display core.
//  - Synchronises and debounces the 7 DIP-switch inputs.
//  - Generates a one-cycle tick enable from a programmable prescaler, so no derived clock is used.
//  - Runs the letter-sequencing FSM and emits letter index, enable and decimal point
//    for the downstream segment decoder.
// PARAMETERS
//  DB_CYCLES  1024  consecutive stable cycles required before sw_clean updates (>=2)
//  PRESC_W    16    prescaler width; rate_sel picks tick period 2^(rate_sel+1)
//  MSG_LEN    5     letters in message; letter_idx counts 0..MSG_LEN-1 (<=8)
//  GAP_TICKS  2     blank ticks inserted after the last letter in RUN mode (>=1)
// PORTS
//  clk         in   1  system clock (io_in[0])
//  rst_n       in   1  asynchronous active-low reset
//  sw_raw      in   7  raw DIP switches (io_in[7:1]), asynchronous to clk
//  sw_clean    out  7  debounced switches; [6]=run, [3:0]=rate_sel, [2:0]=manual idx
//  tick        out  1  one-cycle pulse at the prescaled rate
//  letter_idx  out  3  letter to display, 0..MSG_LEN-1
//  letter_en   out  1  1 = show letter_idx; 0 = blank segments
//  dp          out  1  decimal point drive
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs 0, prescaler 0, debounce count 0, FSM=HOLD.
//  Sync: sw_raw -> s1 -> s2 (2 flops); sync_d = s2 delayed by one cycle.
//  Debounce FSM, whole vector:
//   STABLE: s2==sw_clean; cnt=0.
//   SETTLING: s2!=sw_clean; cnt clears when s2!=sync_d, else cnt+1.
//   cnt==DB_CYCLES-1 with s2==sync_d: sw_clean<=s2, cnt<=0, back to STABLE.
//   Glitch shorter than DB_CYCLES leaves sw_clean unchanged.
//   Latency: clean step on sw_raw -> sw_clean changes on rising edge DB_CYCLES+3.
//  Prescaler: free-running PRESC_W counter, wraps.
//   tick=1 for the cycle after presc[k:0] is all-ones, k=rate_sel.
//   Period 2^(k+1) cycles. A rate_sel change takes effect immediately; the first
//   period after it may be short. Never two ticks in adjacent cycles unless k=0.
//  Sequencer FSM, registered outputs, evaluated each cycle:
//   HOLD (sw_clean[6]=0): letter_idx = sw_clean[2:0] if < MSG_LEN, letter_en=1;
//    else letter_idx=0, letter_en=0. dp=0. Ticks ignored.
//   HOLD->SHOW when sw_clean[6] rises: letter_idx=0, letter_en=1 next cycle;
//    prescaler is not reset.
//   SHOW: on tick, letter_idx<MSG_LEN-1 -> idx+1; idx==MSG_LEN-1 -> GAP, gap_cnt=0, letter_en=0.
//   GAP: letter_en=0, letter_idx holds; on tick gap_cnt+1; when gap_cnt reaches
//    GAP_TICKS, next cycle is SHOW with idx 0. GAP lasts exactly GAP_TICKS ticks.
//   SHOW/GAP: dp toggles on every tick (heartbeat).
//   SHOW/GAP -> HOLD the cycle after sw_clean[6] falls, overriding a same-cycle
//    tick; dp cleared.
//  Async reset mid-sequence: immediate return to reset values; no partial update.
// TESTING
//  DB_CYCLES=4, PRESC_W=8 for all cases.
//  1 Reset: rst_n=0 mid-run -> all outputs 0 asynchronously; after release FSM=HOLD, idx 0.
//  2 Debounce: sw_raw 0->7'h41 held -> sw_clean=7'h41 on edge 7 after change;
//    a 3-cycle pulse of 7'h7F -> sw_clean unchanged.
//  3 Tick rate: rate_sel=2 -> tick every 8 cycles; rate_sel=0 -> every 2 cycles.
//  4 Run sequence: run=1 -> letter_idx 0,1,2,3,4 with letter_en=1 on successive ticks,
//    then letter_en=0 for 2 ticks, then idx 0; dp toggles on each tick.
//  5 Manual: run=0, sw[2:0]=3 -> idx 3, en 1; sw[2:0]=6 -> idx 0, en 0, dp 0.
//  6 Mode race: run falls in the same cycle as a tick in SHOW idx 2 -> next cycle is HOLD;
//    idx follows sw[2:0], no advance to 3.

Source files
------------

// File: rtl/hello_seq_ctrl.sv
// hello_seq_ctrl: switch sync/debounce, prescaled tick and
// letter sequencer feeding the HELLO segment decoder.
module hello_seq_ctrl #(
  parameter int DB_CYCLES = 1024,
  parameter int PRESC_W   = 16,
  parameter int MSG_LEN   = 5,
  parameter int GAP_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] sw_raw,
  output logic [6:0] sw_clean,
  output logic       tick,
  output logic [2:0] letter_idx,
  output logic       letter_en,
  output logic       dp
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  localparam logic [2:0]    LAST    = 3'(MSG_LEN - 1);
  localparam logic [GW-1:0] GAP_END = GW'(GAP_TICKS - 1);

  typedef enum logic {DB_STABLE, DB_SETTLE} db_t;
  typedef enum logic [1:0] {HOLD, SHOW, GAP} seq_t;

  db_t           db_q, db_d;
  logic [6:0]    s1, s2, sync_d, clean_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [PRESC_W-1:0] presc, mask;
  logic [3:0]         rate;
  logic               tick_d;

  seq_t          st_q, st_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0]    idx_d, hold_idx;
  logic          en_d, dp_d, hold_en, run;

  assign rate     = sw_clean[3:0];
  assign run      = sw_clean[6];
  assign hold_en  = {1'b0, sw_clean[2:0]} < 4'(MSG_LEN);
  assign hold_idx = hold_en ? sw_clean[2:0] : 3'd0;

  always_comb begin
    db_d    = db_q;
    cnt_d   = cnt_q;
    clean_d = sw_clean;
    unique case (db_q)
      DB_STABLE: begin
        cnt_d = '0;
        if (s2 != sw_clean) db_d = DB_SETTLE;
      end
      DB_SETTLE: begin
        if (s2 == sw_clean) begin
          db_d  = DB_STABLE;
          cnt_d = '0;
        end else if (s2 != sync_d) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          clean_d = s2;
          cnt_d   = '0;
          db_d    = DB_STABLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // low rate_sel+1 bits all ones -> tick next cycle
  always_comb begin
    mask = '0;
    for (int i = 0; i < PRESC_W; i++)
      mask[i] = (i <= int'(rate));
    tick_d = &(presc | ~mask);
  end

  always_comb begin
    st_d  = st_q;
    gap_d = gap_q;
    idx_d = letter_idx;
    en_d  = letter_en;
    dp_d  = dp;
    unique case (st_q)
      HOLD: begin
        dp_d = 1'b0;
        if (run) begin
          st_d  = SHOW;
          idx_d = '0;
          en_d  = 1'b1;
        end else begin
          idx_d = hold_idx;
          en_d  = hold_en;
        end
      end
      SHOW, GAP: begin
        if (!run) begin
          st_d  = HOLD;
          idx_d = hold_idx;
          en_d  = hold_en;
          dp_d  = 1'b0;
        end else if (tick) begin
          dp_d = ~dp;
          if (st_q == SHOW) begin
            if (letter_idx < LAST) begin
              idx_d = letter_idx + 3'd1;
            end else begin
              st_d  = GAP;
              gap_d = '0;
              en_d  = 1'b0;
            end
          end else if (gap_q == GAP_END) begin
            st_d  = SHOW;
            idx_d = '0;
            en_d  = 1'b1;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      default: st_d = HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= '0;
      s2         <= '0;
      sync_d     <= '0;
      sw_clean   <= '0;
      cnt_q      <= '0;
      db_q       <= DB_STABLE;
      presc      <= '0;
      tick       <= 1'b0;
      st_q       <= HOLD;
      gap_q      <= '0;
      letter_idx <= '0;
      letter_en  <= 1'b0;
      dp         <= 1'b0;
    end else begin
      s1         <= sw_raw;
      s2         <= s1;
      sync_d     <= s2;
      sw_clean   <= clean_d;
      cnt_q      <= cnt_d;
      db_q       <= db_d;
      presc      <= presc + PRESC_W'(1);
      tick       <= tick_d;
      st_q       <= st_d;
      gap_q      <= gap_d;
      letter_idx <= idx_d;
      letter_en  <= en_d;
      dp         <= dp_d;
    end
  end

endmodule

// File: tb/tb_hello_seq_ctrl.sv
// tb_hello_seq_ctrl: vector table plus scoreboard checks
// for debounce, tick rate, run sequence and mode race.
module tb_hello_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] sw_raw = '0;
  logic [6:0] sw_clean;
  logic       tick;
  logic [2:0] letter_idx;
  logic       letter_en;
  logic       dp;

  hello_seq_ctrl #(
    .DB_CYCLES(4),
    .PRESC_W(8),
    .MSG_LEN(5),
    .GAP_TICKS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw_raw(sw_raw),
    .sw_clean(sw_clean),
    .tick(tick),
    .letter_idx(letter_idx),
    .letter_en(letter_en),
    .dp(dp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [6:0] sw;
    logic [2:0] idx;
    logic       en;
  } vec_t;

  typedef struct {
    string      name;
    logic [6:0] sw;
    logic [2:0] idx;
    logic       en;
    logic       dp;
  } exp_t;

  vec_t vt[8];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic chk_out(input exp_t e);
    chk({e.name, ".idx"}, 32'(letter_idx), 32'(e.idx));
    chk({e.name, ".en"}, 32'(letter_en), 32'(e.en));
    chk({e.name, ".dp"}, 32'(dp), 32'(e.dp));
  endtask

  task automatic wait_tick(output int c, output bit ok);
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (tick) begin
        c  = cyc;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic measure(input string name, input logic [6:0] sw,
                         input int period);
    int t0, t1, t2;
    bit k0, k1, k2;
    @(negedge clk);
    sw_raw = sw;
    repeat (12) @(negedge clk);
    wait_tick(t0, k0);
    wait_tick(t1, k1);
    wait_tick(t2, k2);
    chk({name, ".found"}, 32'(k0 & k1 & k2), 1);
    chk({name, ".p1"}, t1 - t0, period);
    chk({name, ".p2"}, t2 - t1, period);
  endtask

  initial begin
    exp_t e;
    int   budget;
    bit   found;

    vt[0] = '{7'h03, 3'd3, 1'b1};
    vt[1] = '{7'h06, 3'd0, 1'b0};
    vt[2] = '{7'h04, 3'd4, 1'b1};
    vt[3] = '{7'h05, 3'd0, 1'b0};
    vt[4] = '{7'h00, 3'd0, 1'b1};
    vt[5] = '{7'h07, 3'd0, 1'b0};
    vt[6] = '{7'h01, 3'd1, 1'b1};
    vt[7] = '{7'h02, 3'd2, 1'b1};

    // reset values, then HOLD with switches at zero
    repeat (2) @(negedge clk);
    chk("rst.sw_clean", 32'(sw_clean), 0);
    chk("rst.tick", 32'(tick), 0);
    chk("rst.idx", 32'(letter_idx), 0);
    chk("rst.en", 32'(letter_en), 0);
    chk("rst.dp", 32'(dp), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("hold0.idx", 32'(letter_idx), 0);
    chk("hold0.en", 32'(letter_en), 1);

    // debounce latency: change lands on edge 7
    @(negedge clk);
    sw_raw = 7'h41;
    repeat (6) @(posedge clk);
    #1 chk("db.edge6", 32'(sw_clean), 0);
    @(posedge clk);
    #1 chk("db.edge7", 32'(sw_clean), 32'h41);

    // 3-cycle glitch is filtered
    @(negedge clk);
    sw_raw = 7'h7F;
    repeat (3) @(negedge clk);
    sw_raw = 7'h41;
    repeat (12) begin
      @(negedge clk);
      chk("db.glitch", 32'(sw_clean), 32'h41);
    end

    // manual mode table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sw_raw = vt[i].sw;
      sb.push_back('{$sformatf("man%0d", i), vt[i].sw,
                     vt[i].idx, vt[i].en, 1'b0});
      repeat (10) @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      chk({e.name, ".sw"}, 32'(sw_clean), 32'(e.sw));
      chk_out(e);
    end

    // tick periods
    measure("rate2", 7'h02, 8);
    measure("rate0", 7'h00, 2);
    measure("rate15", 7'h0F, 256);

    // run sequence at rate_sel=1
    @(negedge clk);
    sw_raw = 7'h41;
    sb.push_back('{"run1", 7'h41, 3'd1, 1'b1, 1'b1});
    sb.push_back('{"run2", 7'h41, 3'd2, 1'b1, 1'b0});
    sb.push_back('{"run3", 7'h41, 3'd3, 1'b1, 1'b1});
    sb.push_back('{"run4", 7'h41, 3'd4, 1'b1, 1'b0});
    sb.push_back('{"gap1", 7'h41, 3'd4, 1'b0, 1'b1});
    sb.push_back('{"gap2", 7'h41, 3'd4, 1'b0, 1'b0});
    sb.push_back('{"wrap0", 7'h41, 3'd0, 1'b1, 1'b1});
    sb.push_back('{"wrap1", 7'h41, 3'd1, 1'b1, 1'b0});
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk_out('{"show_entry", 7'h41, 3'd0, 1'b1, 1'b0});
    budget = 200;
    while (sb.size() > 0 && budget > 0) begin
      if (tick) begin
        @(negedge clk);
        e = sb.pop_front();
        chk_out(e);
      end else begin
        @(negedge clk);
      end
      budget--;
    end
    chk("run.pending", sb.size(), 0);
    sb.delete();

    // run falls on the same cycle as a tick at idx 2
    @(negedge clk);
    sw_raw = 7'h40;
    repeat (12) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (tick && letter_en && letter_idx == 3'd2) found = 1'b1;
      else @(negedge clk);
    end
    chk("race.sync", 32'(found), 1);
    if (found) begin
      // full loop is 7 ticks of 2 cycles
      repeat (7) @(negedge clk);
      sw_raw = 7'h04;
      repeat (7) @(posedge clk);
      @(negedge clk);
      chk("race.tick", 32'(tick), 1);
      chk("race.pre_idx", 32'(letter_idx), 2);
      chk("race.sw", 32'(sw_clean), 32'h04);
      @(negedge clk);
      chk_out('{"race.hold", 7'h04, 3'd4, 1'b1, 1'b0});
      @(negedge clk);
      chk_out('{"race.hold2", 7'h04, 3'd4, 1'b1, 1'b0});
    end

    // async reset in the middle of a run
    @(negedge clk);
    sw_raw = 7'h41;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.sw_clean", 32'(sw_clean), 0);
    chk("arst.tick", 32'(tick), 0);
    chk("arst.idx", 32'(letter_idx), 0);
    chk("arst.en", 32'(letter_en), 0);
    chk("arst.dp", 32'(dp), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst.hold_idx", 32'(letter_idx), 0);
    chk("arst.hold_en", 32'(letter_en), 1);
    chk("arst.hold_dp", 32'(dp), 0);
    chk("arst.hold_sw", 32'(sw_clean), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
